// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared widths, FSM states and SHA-256 sigma functions for the message schedule
package sha256_pkg;

    localparam int MSG_W  = 1024;
    localparam int BLK_W  = 512;
    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;
    localparam int WIN_N  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BLK0 = 2'd1,
        BLK1 = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sha256_s0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sha256_s1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - message-in / schedule-word-out handshake bundle
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic [MSG_W-1:0]  msg_in;
    logic              msg_valid;
    logic              msg_ready;
    logic [WORD_W-1:0] w_out;
    logic              w_valid;
    logic              w_ready;
    logic [5:0]        w_idx;
    logic              blk_idx;
    logic              blk_last;

    modport master (
        output msg_in, msg_valid, w_ready,
        input  msg_ready, w_out, w_valid, w_idx, blk_idx, blk_last
    );

    modport slave (
        input  msg_in, msg_valid, w_ready,
        output msg_ready, w_out, w_valid, w_idx, blk_idx, blk_last
    );

endinterface

// File: rtl/sha256_sched_word.sv
// rtl/sha256_sched_word.sv - combinational next schedule word from the 16-word window taps
module sha256_sched_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_w0,
    input  logic [WORD_W-1:0] i_w1,
    input  logic [WORD_W-1:0] i_w9,
    input  logic [WORD_W-1:0] i_w14,
    output logic [WORD_W-1:0] o_next
);

    assign o_next = sha256_s1(i_w14) + i_w9 + sha256_s0(i_w1) + i_w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - streams W[0..63] per block; MSG_SCHED_MIDSTATE_EN emits block 1 only
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_schedule_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_win [WIN_N];
    logic [5:0]         r_idx;
    logic [WORD_W-1:0]  w_next;
    logic               w_accept;
    logic               w_adv;
    logic               w_last_word;

`ifndef MSG_SCHED_MIDSTATE_EN
    logic [BLK_W-1:0]   r_hold;
`endif

    assign w_accept    = bus.msg_valid && (r_state == IDLE);
    assign w_adv       = bus.w_valid && bus.w_ready;
    assign w_last_word = (r_idx == 6'(ROUNDS - 1));

    assign bus.msg_ready = (r_state == IDLE);
    assign bus.w_valid   = (r_state != IDLE);
    assign bus.w_out     = r_win[0];
    assign bus.w_idx     = r_idx;
    assign bus.blk_idx   = (r_state == BLK1);
    assign bus.blk_last  = (r_state == BLK1) && w_last_word;

    sha256_sched_word u_word (
        .i_w0   (r_win[0]),
        .i_w1   (r_win[1]),
        .i_w9   (r_win[9]),
        .i_w14  (r_win[14]),
        .o_next (w_next)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
`ifdef MSG_SCHED_MIDSTATE_EN
                if (w_accept) w_state_nxt = BLK1;
`else
                if (w_accept) w_state_nxt = BLK0;
`endif
            end
            BLK0:    if (w_adv && w_last_word) w_state_nxt = BLK1;
            BLK1:    if (w_adv && w_last_word) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            for (int i = 0; i < WIN_N; i++) r_win[i] <= '0;
`ifndef MSG_SCHED_MIDSTATE_EN
            r_hold  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx <= '0;
                // Word 0 of a block is its most significant 32 bits.
                for (int i = 0; i < WIN_N; i++) begin
`ifdef MSG_SCHED_MIDSTATE_EN
                    r_win[i] <= bus.msg_in[BLK_W-1-WORD_W*i -: WORD_W];
`else
                    r_win[i] <= bus.msg_in[MSG_W-1-WORD_W*i -: WORD_W];
`endif
                end
`ifndef MSG_SCHED_MIDSTATE_EN
                r_hold <= bus.msg_in[BLK_W-1:0];
`endif
            end else if (w_adv) begin
                // Index wraps 63->0 naturally at block boundaries.
                r_idx <= r_idx + 6'd1;
`ifndef MSG_SCHED_MIDSTATE_EN
                if ((r_state == BLK0) && w_last_word) begin
                    for (int i = 0; i < WIN_N; i++)
                        r_win[i] <= r_hold[BLK_W-1-WORD_W*i -: WORD_W];
                end else
`endif
                begin
                    for (int i = 0; i < WIN_N - 1; i++) r_win[i] <= r_win[i+1];
                    r_win[WIN_N-1] <= w_next;
                end
            end
        end
    end

endmodule
